instruction_encoder: RTL and testbench
======================================

# instruction_encoder

Streaming RV32I instruction encoder and loader: accepts decoded-form instruction descriptors (class, ALU control code, func3, register fields, immediate) over a valid/ready handshake, packs each into a 32-bit RV32I word, and writes consecutive words into instruction memory. It is the inverse of the ID-stage decoder. Its ALU control codes match the ID/EX control encoding, so a descriptor that is encoded here and then decoded in ID reproduces the same control fields. It sits beside the core's instruction memory and is used for boot/program load and for self-checking test generation.

## Interface
- DEPTH, 256, capacity in words (written words per program)
- ADDR_W, 8, imem word-address width, 2^ADDR_W ≥ DEPTH
- BASE_ADDR, 0, first word address written after start
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin new program: clear pointer/count/err, flush pipeline, enter RUN
- finish  in  1  end of program: drain pipeline, then DONE
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid & in_ready
- in_class  in  4  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, 9–15 illegal
- in_alu_op  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
- in_func3  in  3  width (LOAD/STORE) or condition (BRANCH); passed through
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_imm  in  32  signed byte offset/immediate; U-type supplies full value (imm[31:12] used)
- imem_we  out  1  write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- word_count  out  ADDR_W+1  words written since start
- err  out  1  sticky: at least one descriptor dropped
- done  out  1  high while in DONE

## Operation
- FSM: IDLE → RUN on start; RUN → DRAIN on finish; DRAIN → DONE when both pipeline stages empty; start from any state → RUN.
- in_ready = (state == RUN) & ~start & (acc_cnt < DEPTH).
- acc_cnt counts accepted, not-dropped descriptors. A descriptor accepted together with finish is processed.
- Stage 1 registers the descriptor. Stage 2 registers the encoded word, address and write strobe.
- Encoding:
  - R: func3 from alu_op (ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111); func7 = 0100000 for SUB/SRA, else 0.
  - I-ALU: same func3 mapping. For shifts, imm[11:5] = 0100000 for SRA, else 0, and imm[4:0] = in_imm[4:0]. alu_op SUB is illegal.
  - LOAD (0000011) and JALR (1100111, func3 000) use I-format.
  - STORE uses S-split; BRANCH uses B-split of in_imm[12:1].
  - LUI 0110111 and AUIPC 0010111 take in_imm[31:12].
  - JAL 1101111 uses J-split of in_imm[20:1].
  - R/I-ALU with alu_op > 9 is illegal.
- An illegal descriptor is dropped: no write, pointer and count unchanged, err set, acc_cnt decremented. Simultaneous accept and drop leaves acc_cnt unchanged.
- Each write: imem_addr = BASE_ADDR + word_count; word_count increments the same cycle.

## Timing
- Reset: in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, word_count 0, err 0, done 0, state IDLE, both stages empty.
- Latency: a descriptor accepted at edge N produces imem_we = 1 in cycle N+2. Throughput is one word per cycle.
- start asserted in any cycle: in-flight stage contents are discarded (no imem_we the next cycle); word_count, acc_cnt and err clear.
- rst_n low mid-operation suppresses any pending write from that edge.
- Full: acc_cnt == DEPTH drops in_ready the cycle after the DEPTH-th accept. In-flight words still complete.
- finish while the pipeline is empty: DRAIN lasts one cycle, then done = 1.

## Configuration
- ENC_RANGE_CHECK_EN defined: immediates are range-checked before packing; a violation is dropped with err set.
  - I/S: signed 12-bit.
  - B: signed 13-bit, bit0 = 0.
  - J: signed 21-bit, bit0 = 0.
  - Shifts: in_imm[31:5] = 0.
  - U: in_imm[11:0] = 0.
- Undefined: immediates are silently truncated to field width; only illegal class/alu_op drops.

## Test plan
- start, then I-ALU ADD rd1 rs1 0 imm 5 → imem_we 2 cycles after accept, addr 0, data 0x00500093; word_count 1.
- Back-to-back R ADD x3,x1,x2 then SUB → 0x002081B3 at addr 0, 0x402081B3 at addr 1 on consecutive cycles.
- STORE func3 010 rs1 1 rs2 2 imm 8 → 0x0020A423; BRANCH func3 000 rs1 1 rs2 2 imm −4 → 0xFE208EE3; LUI rd5 imm 0x12345000 → 0x123452B7; JAL rd1 imm 8 → 0x008000EF; I-ALU SRA rd4 rs1 4 imm 3 → 0x40325213.
- With ENC_RANGE_CHECK_EN: ADDI imm 2048 → no write, err 1, word_count unchanged; next valid descriptor is written at the unchanged address.
- DEPTH = 4: stream 6 descriptors → in_ready low after 4th accept, 4 writes at addresses 0–3; finish → done 1 two cycles after last write.
- start issued the cycle after an accept → no write for that descriptor; word_count 0; err cleared.

Source files
------------

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs RV32I descriptors into 32-bit words and streams them into imem.
// Optional macro ENC_RANGE_CHECK_EN: drop descriptors whose immediate does not fit its field.
module instruction_encoder #(
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [3:0]        in_alu_op,
    input  logic [2:0]        in_func3,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              err,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_V  = ADDR_W'(BASE_ADDR);

    state_t            state;
    logic [ADDR_W:0]   acc_cnt;

    logic              s1_valid;
    logic [3:0]        s1_class;
    logic [3:0]        s1_op;
    logic [2:0]        s1_f3;
    logic [4:0]        s1_rd;
    logic [4:0]        s1_rs1;
    logic [4:0]        s1_rs2;
    logic [31:0]       s1_imm;

    logic [2:0]        alu_f3;
    logic              alt;
    logic              shift;
    logic              op_ok;
    logic [11:0]       i_imm;
    logic [11:0]       sh_imm;
    logic              i_fit;
    logic              b_fit;
    logic              j_fit;
    logic              sh_fit;
    logic              u_fit;
    logic              enc_ok;
    logic [31:0]       enc_word;
    logic              accept;
    logic              drop;

    assign in_ready = (state == RUN) & ~start & (acc_cnt < DEPTH_V);
    assign accept   = in_valid & in_ready;
    assign drop     = s1_valid & ~enc_ok;

    // ALU control code to func3 and the func7/imm[11:5] alternate bit
    always_comb begin
        alu_f3 = 3'b000;
        case (s1_op)
            4'd2:    alu_f3 = 3'b001;
            4'd3:    alu_f3 = 3'b010;
            4'd4:    alu_f3 = 3'b011;
            4'd5:    alu_f3 = 3'b100;
            4'd6:    alu_f3 = 3'b101;
            4'd7:    alu_f3 = 3'b101;
            4'd8:    alu_f3 = 3'b110;
            4'd9:    alu_f3 = 3'b111;
            default: alu_f3 = 3'b000;
        endcase
    end

    assign alt    = (s1_op == 4'd1) | (s1_op == 4'd7);
    assign shift  = (s1_op == 4'd2) | (s1_op == 4'd6) | (s1_op == 4'd7);
    assign op_ok  = (s1_op <= 4'd9);
    assign i_imm  = s1_imm[11:0];
    assign sh_imm = {(alt ? 7'b0100000 : 7'b0000000), s1_imm[4:0]};

`ifdef ENC_RANGE_CHECK_EN
    assign i_fit  = (&s1_imm[31:11]) | ~(|s1_imm[31:11]);
    assign b_fit  = ((&s1_imm[31:12]) | ~(|s1_imm[31:12])) & ~s1_imm[0];
    assign j_fit  = ((&s1_imm[31:20]) | ~(|s1_imm[31:20])) & ~s1_imm[0];
    assign sh_fit = ~(|s1_imm[31:5]);
    assign u_fit  = ~(|s1_imm[11:0]);
`else
    assign i_fit  = 1'b1;
    assign b_fit  = 1'b1;
    assign j_fit  = 1'b1;
    assign sh_fit = 1'b1;
    assign u_fit  = 1'b1;
`endif

    // Pack the stage-1 descriptor into an RV32I word and flag illegal ones
    always_comb begin
        enc_ok   = 1'b0;
        enc_word = 32'h0;
        case (s1_class)
            4'd0: begin
                enc_ok   = op_ok;
                enc_word = {(alt ? 7'b0100000 : 7'b0000000), s1_rs2, s1_rs1,
                            alu_f3, s1_rd, 7'b0110011};
            end
            4'd1: begin
                enc_ok   = op_ok & (s1_op != 4'd1) & (shift ? sh_fit : i_fit);
                enc_word = {(shift ? sh_imm : i_imm), s1_rs1, alu_f3, s1_rd,
                            7'b0010011};
            end
            4'd2: begin
                enc_ok   = i_fit;
                enc_word = {i_imm, s1_rs1, s1_f3, s1_rd, 7'b0000011};
            end
            4'd3: begin
                enc_ok   = i_fit;
                enc_word = {i_imm[11:5], s1_rs2, s1_rs1, s1_f3, i_imm[4:0],
                            7'b0100011};
            end
            4'd4: begin
                enc_ok   = b_fit;
                enc_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                            s1_imm[4:1], s1_imm[11], 7'b1100011};
            end
            4'd5: begin
                enc_ok   = u_fit;
                enc_word = {s1_imm[31:12], s1_rd, 7'b0110111};
            end
            4'd6: begin
                enc_ok   = u_fit;
                enc_word = {s1_imm[31:12], s1_rd, 7'b0010111};
            end
            4'd7: begin
                enc_ok   = j_fit;
                enc_word = {s1_imm[20], s1_imm[10:1], s1_imm[11],
                            s1_imm[19:12], s1_rd, 7'b1101111};
            end
            4'd8: begin
                enc_ok   = i_fit;
                enc_word = {i_imm, s1_rs1, 3'b000, s1_rd, 7'b1100111};
            end
            default: begin
                enc_ok   = 1'b0;
                enc_word = 32'h0;
            end
        endcase
    end

    // Program-level FSM; done is registered alongside the state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else if (start) begin
            state <= RUN;
            done  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (finish) state <= DRAIN;
                end
                DRAIN: begin
                    if (!s1_valid && !imem_we) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    // Two-stage datapath: descriptor capture, then encoded write to imem
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_class   <= '0;
            s1_op      <= '0;
            s1_f3      <= '0;
            s1_rd      <= '0;
            s1_rs1     <= '0;
            s1_rs2     <= '0;
            s1_imm     <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_count <= '0;
            acc_cnt    <= '0;
            err        <= 1'b0;
        end else if (start) begin
            s1_valid   <= 1'b0;
            imem_we    <= 1'b0;
            word_count <= '0;
            acc_cnt    <= '0;
            err        <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_class <= in_class;
                s1_op    <= in_alu_op;
                s1_f3    <= in_func3;
                s1_rd    <= in_rd;
                s1_rs1   <= in_rs1;
                s1_rs2   <= in_rs2;
                s1_imm   <= in_imm;
            end
            imem_we <= s1_valid & enc_ok;
            if (s1_valid && enc_ok) begin
                imem_wdata <= enc_word;
                imem_addr  <= BASE_V + word_count[ADDR_W-1:0];
                word_count <= word_count + 1'b1;
            end
            if (drop) err <= 1'b1;
            case ({accept, drop})
                2'b10:   acc_cnt <= acc_cnt + 1'b1;
                2'b01:   acc_cnt <= acc_cnt - 1'b1;
                default: acc_cnt <= acc_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed program-load cases plus random streams
// checked against a field-arithmetic reference encoder and program model.
module tb_instruction_encoder;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 4;
    localparam int BASE   = 3;

    typedef struct {
        logic [3:0]  cls;
        logic [3:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } desc_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              finish;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_class;
    logic [3:0]        in_alu_op;
    logic [2:0]        in_func3;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              err;
    logic              done;

    always #5 clk = ~clk;

    instruction_encoder #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_alu_op(in_alu_op), .in_func3(in_func3),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .word_count(word_count), .err(err), .done(done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model: mode 0 idle, 1 run, 2 drain, 3 done
    int          m_mode, m_acc, m_cnt;
    bit          m_err;
    bit          p1v, p1ok, p2v;
    logic [31:0] p1w, p2w;
    int          p2a;
    logic [31:0] seen[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic desc_t mk(input int c, input int o, input int f,
                                 input int d, input int s1, input int s2,
                                 input logic [31:0] im);
        desc_t r;
        r.cls = 4'(c); r.op = 4'(o); r.f3 = 3'(f);
        r.rd = 5'(d); r.rs1 = 5'(s1); r.rs2 = 5'(s2); r.imm = im;
        return r;
    endfunction

    // reference encoder: returns {legal, word}, built with field arithmetic
    function automatic logic [32:0] ref_enc(input desc_t d);
        int unsigned ftab[16] = '{0,0,1,2,3,4,5,5,6,7,0,0,0,0,0,0};
        int unsigned rd  = d.rd;
        int unsigned rs1 = d.rs1;
        int unsigned rs2 = d.rs2;
        int unsigned f3  = d.f3;
        int unsigned af3 = ftab[d.op];
        int unsigned im  = d.imm;
        int unsigned i12 = im % 4096;
        int          s   = $signed(d.imm);
        bit sh  = (d.op == 2) || (d.op == 6) || (d.op == 7);
        bit alt = (d.op == 1) || (d.op == 7);
        bit f12 = 1, f13 = 1, f21 = 1, fsh = 1, fu = 1;
        bit ok  = 1;
        int unsigned w = 0;
        int unsigned b, j;
`ifdef ENC_RANGE_CHECK_EN
        f12 = (s >= -2048) && (s <= 2047);
        f13 = (s >= -4096) && (s <= 4095) && (im % 2 == 0);
        f21 = (s >= -1048576) && (s <= 1048575) && (im % 2 == 0);
        fsh = im < 32;
        fu  = (im % 4096) == 0;
`endif
        case (d.cls)
            0: begin
                ok = d.op <= 9;
                w  = (alt ? 32 : 0) * (1 << 25) + rs2 * (1 << 20)
                   + rs1 * (1 << 15) + af3 * (1 << 12) + rd * 128 + 'h33;
            end
            1: begin
                ok = (d.op <= 9) && (d.op != 1) && (sh ? fsh : f12);
                if (sh) i12 = (alt ? 1024 : 0) + im % 32;
                w  = i12 * (1 << 20) + rs1 * (1 << 15) + af3 * (1 << 12)
                   + rd * 128 + 'h13;
            end
            2: begin
                ok = f12;
                w  = i12 * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12)
                   + rd * 128 + 'h03;
            end
            3: begin
                ok = f12;
                w  = (i12 / 32) * (1 << 25) + rs2 * (1 << 20)
                   + rs1 * (1 << 15) + f3 * (1 << 12) + (i12 % 32) * 128
                   + 'h23;
            end
            4: begin
                ok = f13;
                b  = im % 8192;
                w  = (b / 4096) * (1 << 31) + ((b / 32) % 64) * (1 << 25)
                   + rs2 * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12)
                   + ((b / 2) % 16) * 256 + ((b / 2048) % 2) * 128 + 'h63;
            end
            5: begin
                ok = fu;
                w  = (im / 4096) * 4096 + rd * 128 + 'h37;
            end
            6: begin
                ok = fu;
                w  = (im / 4096) * 4096 + rd * 128 + 'h17;
            end
            7: begin
                ok = f21;
                j  = im % (1 << 21);
                w  = (j / (1 << 20)) * (1 << 31) + ((j / 2) % 1024) * (1 << 21)
                   + ((j / 2048) % 2) * (1 << 20) + ((j / 4096) % 256) * 4096
                   + rd * 128 + 'h6f;
            end
            8: begin
                ok = f12;
                w  = i12 * (1 << 20) + rs1 * (1 << 15) + rd * 128 + 'h67;
            end
            default: ok = 0;
        endcase
        return {ok, w};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_acc = 0; m_cnt = 0; m_err = 0;
        p1v = 0; p1ok = 0; p2v = 0; p1w = 0; p2w = 0; p2a = 0;
    endtask

    // drive one cycle, check outputs, then advance the model over the edge
    task automatic step(input bit r, input bit s, input bit f, input bit v,
                        input desc_t d);
        bit rdy, take, o1, o2;
        rst_n = r; start = s; finish = f; in_valid = v;
        in_class = d.cls; in_alu_op = d.op; in_func3 = d.f3;
        in_rd = d.rd; in_rs1 = d.rs1; in_rs2 = d.rs2; in_imm = d.imm;
        #1;
        rdy = (m_mode == 1) && !s && (m_acc < DEPTH);
        check("in_ready", 32'(in_ready), 32'(rdy));
        check("imem_we", 32'(imem_we), 32'(p2v));
        if (p2v) begin
            check("imem_addr", 32'(imem_addr), 32'(p2a));
            check("imem_wdata", imem_wdata, p2w);
        end
        if (imem_we) seen.push_back(imem_wdata);
        check("word_count", 32'(word_count), 32'(m_cnt));
        check("err", 32'(err), 32'(m_err));
        check("done", 32'(done), 32'(m_mode == 3));
        @(posedge clk);
        take = v && rdy;
        if (!r) begin
            model_reset();
        end else if (s) begin
            m_mode = 1; p1v = 0; p2v = 0; m_cnt = 0; m_acc = 0; m_err = 0;
        end else begin
            o1 = p1v; o2 = p2v;
            if (p1v && p1ok) begin
                p2v = 1; p2w = p1w; p2a = (BASE + m_cnt) % (1 << ADDR_W);
                m_cnt++;
            end else begin
                p2v = 0;
                if (p1v) begin m_err = 1; m_acc--; end
            end
            p1v = take;
            if (take) begin {p1ok, p1w} = ref_enc(d); m_acc++; end
            if (m_mode == 1 && f) m_mode = 2;
            else if (m_mode == 2 && !o1 && !o2) m_mode = 3;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, mk(0,0,0,0,0,0,0));
    endtask

    desc_t       dir[$];
    logic [31:0] dexp[$];

    initial begin
        desc_t z;
        int    base_n;
        z = mk(0,0,0,0,0,0,0);
        rst_n = 0; start = 0; finish = 0; in_valid = 0;
        in_class = 0; in_alu_op = 0; in_func3 = 0;
        in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_addr", 32'(imem_addr), 32'h0);
        check("rst_wdata", imem_wdata, 32'h0);
        check("rst_ready", 32'(in_ready), 32'h0);
        step(0, 0, 0, 0, z);

        dir.push_back(mk(1, 0, 0, 1, 0, 0, 32'd5));
        dir.push_back(mk(0, 0, 0, 3, 1, 2, 32'd0));
        dir.push_back(mk(0, 1, 0, 3, 1, 2, 32'd0));
        dir.push_back(mk(3, 0, 2, 0, 1, 2, 32'd8));
        dir.push_back(mk(4, 0, 0, 0, 1, 2, 32'hFFFF_FFFC));
        dir.push_back(mk(5, 0, 0, 5, 0, 0, 32'h1234_5000));
        dir.push_back(mk(7, 0, 0, 1, 0, 0, 32'd8));
        dir.push_back(mk(1, 7, 0, 4, 4, 0, 32'd3));
        dexp = '{32'h00500093, 32'h002081B3, 32'h402081B3, 32'h0020A423,
                 32'hFE208EE3, 32'h123452B7, 32'h008000EF, 32'h40325213};

        step(1, 1, 0, 0, z);
        foreach (dir[i]) step(1, 0, 0, 1, dir[i]);
        step(1, 0, 0, 1, dir[0]);
        step(1, 0, 1, 1, dir[1]);
        idle(4);
        check("dir_writes", 32'(seen.size()), 32'd8);
        foreach (dexp[i]) begin
            if (i < seen.size()) check($sformatf("dir_word%0d", i), seen[i], dexp[i]);
        end
        check("full_count", 32'(word_count), 32'd8);
        check("done_final", 32'(done), 32'd1);

        step(1, 1, 0, 0, z);
        step(1, 0, 0, 1, mk(12, 0, 0, 1, 1, 1, 32'd1));
        step(1, 0, 0, 1, mk(1, 0, 0, 2, 0, 0, 32'd7));
        idle(3);
        check("illegal_err", 32'(err), 32'd1);
        check("illegal_cnt", 32'(word_count), 32'd1);

        base_n = seen.size();
        step(1, 0, 0, 1, mk(1, 0, 0, 1, 0, 0, 32'd5));
        step(1, 1, 0, 0, z);
        idle(3);
        check("flush_writes", 32'(seen.size()), 32'(base_n));
        check("flush_cnt", 32'(word_count), 32'd0);
        check("flush_err", 32'(err), 32'd0);

        for (int c = 0; c < 4000; c++) begin
            desc_t d;
            bit r, s, f, v;
            d.cls = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(9, 15))
                                                 : 4'($urandom_range(0, 8));
            d.op  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                : 4'($urandom_range(0, 9));
            d.f3  = 3'($urandom);
            d.rd  = 5'($urandom);
            d.rs1 = 5'($urandom);
            d.rs2 = 5'($urandom);
            case ($urandom_range(0, 3))
                0: d.imm = 32'($signed(12'($urandom)));
                1: d.imm = 32'($urandom_range(0, 31));
                2: d.imm = $urandom & 32'hFFFF_F000;
                default: d.imm = $urandom;
            endcase
            r = $urandom_range(0, 499) != 0;
            s = $urandom_range(0, 39) == 0;
            f = $urandom_range(0, 29) == 0;
            v = $urandom_range(0, 3) != 0;
            step(r, s, f, v, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
